seq_shift_add_multiplier: RTL and testbench

//  Parametrised multi-cycle shift-add multiplier: one multiplier bit per clock, full 2*WIDTH product.

---
 rtl/seq_shift_add_multiplier_pkg.sv | 13 +
 rtl/mult_shift_add_step.sv | 28 ++
 rtl/seq_shift_add_multiplier.sv | 216 +++++++++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier family:
// FSM state encodings and the default operand width.
package seq_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mult_shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// accumulator half (carry kept in the extra bit), then shift the whole
// {acc_hi, acc_lo} pair right by one.
module mult_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH:0]   acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0] sum_s;

    // Add-if-LSB-set followed by a logical right shift of the double accumulator
    always_comb begin
        sum_s = acc_hi_i;
        if (acc_lo_i[0]) begin
            sum_s = acc_hi_i + {1'b0, mcand_i};
        end else begin
            sum_s = acc_hi_i;
        end
        acc_hi_o = {1'b0, sum_s[WIDTH:1]};
        acc_lo_o = {sum_s[0], acc_lo_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, full
// 2*WIDTH product, valid/ready on both sides, fixed WIDTH-cycle latency.
// Optional feature macro: MULT_SIGNED_EN adds the signed_i port and
// two's-complement operand handling (magnitude multiply + final negate).
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
`ifdef MULT_SIGNED_EN
    input  logic               signed_i,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mult_state_e        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               accept_s;
    logic               last_step_s;
    logic [WIDTH:0]     acc_hi_step_s;
    logic [WIDTH-1:0]   acc_lo_step_s;
    logic [WIDTH-1:0]   a_load_s;
    logic [WIDTH-1:0]   b_load_s;
    logic               sign_load_s;
    logic [2*WIDTH-1:0] raw_prod_s;
    logic [2*WIDTH-1:0] final_prod_s;

    assign accept_s    = in_valid && in_ready_q;
    assign last_step_s = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
    assign raw_prod_s  = {acc_hi_step_s[WIDTH-1:0], acc_lo_step_s};

    mult_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .mcand_i  (mcand_q),
        .acc_hi_o (acc_hi_step_s),
        .acc_lo_o (acc_lo_step_s)
    );

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic sign_q;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned
    always_comb begin
        a_load_s    = a_i;
        b_load_s    = b_i;
        sign_load_s = 1'b0;
        if (signed_i) begin
            a_load_s    = a_i[WIDTH-1] ? (~a_i + ONE_W) : a_i;
            b_load_s    = b_i[WIDTH-1] ? (~b_i + ONE_W) : b_i;
            sign_load_s = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end else begin
            a_load_s    = a_i;
            b_load_s    = b_i;
            sign_load_s = 1'b0;
        end
    end

    // Result sign captured with the operands so inputs are free after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else if (accept_s) begin
            sign_q <= sign_load_s;
        end else begin
            sign_q <= sign_q;
        end
    end

    assign final_prod_s = sign_q ? (~raw_prod_s + ONE_2W) : raw_prod_s;
`else
    assign a_load_s     = a_i;
    assign b_load_s     = b_i;
    assign sign_load_s  = 1'b0;
    assign final_prod_s = raw_prod_s;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept, WIDTH shift-add steps, then wait for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_BUSY;
                else          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_step_s) state_d = ST_DONE;
                else             state_d = ST_BUSY;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
            ST_BUSY: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Handshake/status output registers; in_ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand load on accept, one shift-add iteration per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {WIDTH{1'b0}};
            acc_hi_q <= {(WIDTH+1){1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            mcand_q  <= a_load_s;
            acc_hi_q <= {(WIDTH+1){1'b0}};
            acc_lo_q <= b_load_s;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (state_q == ST_BUSY) begin
            mcand_q  <= mcand_q;
            acc_hi_q <= acc_hi_step_s;
            acc_lo_q <= acc_lo_step_s;
            cnt_q    <= cnt_q + CNT_ONE;
        end else begin
            mcand_q  <= mcand_q;
            acc_hi_q <= acc_hi_q;
            acc_lo_q <= acc_lo_q;
            cnt_q    <= cnt_q;
        end
    end

    // Product captured on the final step and held stable through the DONE handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= {(2*WIDTH){1'b0}};
        end else if (last_step_s) begin
            product_q <= final_prod_s;
        end else begin
            product_q <= product_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy_o    = busy_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: a 32-bit and an 8-bit
// instance, directed operand vectors with hand-computed products.
// Signed vectors are exercised when MULT_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, busy0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0;
    logic [63:0] prod0;
    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, busy1;
    logic [7:0]  a1 = 8'd0, b1 = 8'd0;
    logic [15:0] prod1;
`ifdef MULT_SIGNED_EN
    logic        sgn0 = 1'b0, sgn1 = 1'b0;
`endif

    logic [63:0] eq0[$], eq1[$];
    int          et0[$], et1[$];
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [63:0] held0 = 64'd0, held1 = 64'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_add_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a_i(a0), .b_i(b0),
`ifdef MULT_SIGNED_EN
        .signed_i(sgn0),
`endif
        .out_valid(out_valid0), .out_ready(out_ready0), .product_o(prod0), .busy_o(busy0)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_i(a1), .b_i(b1),
`ifdef MULT_SIGNED_EN
        .signed_i(sgn1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .product_o(prod1), .busy_o(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp);
        int n = 0;
        @(posedge clk); #1;
        in_valid0 = 1'b1; a0 = a; b0 = b;
`ifdef MULT_SIGNED_EN
        sgn0 = s;
`endif
        while (!in_ready0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("accept_timeout32");
        @(posedge clk); #1;
        eq0.push_back(exp); et0.push_back(cyc);
        in_valid0 = 1'b0; a0 = ~a; b0 = ~b;
`ifdef MULT_SIGNED_EN
        sgn0 = ~s;
`endif
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp);
        int n = 0;
        @(posedge clk); #1;
        in_valid1 = 1'b1; a1 = a; b1 = b;
`ifdef MULT_SIGNED_EN
        sgn1 = s;
`endif
        while (!in_ready1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("accept_timeout8");
        @(posedge clk); #1;
        eq1.push_back({48'd0, exp}); et1.push_back(cyc);
        in_valid1 = 1'b0; a1 = ~a; b1 = ~b;
`ifdef MULT_SIGNED_EN
        sgn1 = ~s;
`endif
    endtask

    task automatic drain();
        int n = 0;
        while ((eq0.size() != 0 || eq1.size() != 0) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 400) fail_now("drain_timeout");
    endtask

    // Monitor for the 32-bit instance: result/latency on rise, stability while held
    always @(negedge clk) begin
        if (rst_n && out_valid0) begin
            chk("inrdy_done32", {63'd0, in_ready0}, 64'd0);
            chk("busy_done32", {63'd0, busy0}, 64'd1);
            if (!pv0) begin
                if (eq0.size() == 0) begin
                    fail_now("unexpected_out32");
                end else begin
                    chk("prod32", prod0, eq0[0]);
                    chk("lat32", 64'(cyc), 64'(et0[0] + 32));
                end
            end else begin
                chk("hold32", prod0, held0);
            end
            held0 <= prod0;
            if (out_ready0 && eq0.size() != 0) begin
                void'(eq0.pop_front()); void'(et0.pop_front());
            end
        end
        pv0 <= rst_n && out_valid0 && !out_ready0;
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (!pv1) begin
                if (eq1.size() == 0) begin
                    fail_now("unexpected_out8");
                end else begin
                    chk("prod8", {48'd0, prod1}, eq1[0]);
                    chk("lat8", 64'(cyc), 64'(et1[0] + 8));
                end
            end else begin
                chk("hold8", {48'd0, prod1}, held1);
            end
            held1 <= {48'd0, prod1};
            if (out_ready1 && eq1.size() != 0) begin
                void'(eq1.pop_front()); void'(et1.pop_front());
            end
        end
        pv1 <= rst_n && out_valid1 && !out_ready1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_inrdy", {63'd0, in_ready0}, 64'd0);
        chk("rst_ovalid", {63'd0, out_valid0}, 64'd0);
        chk("rst_busy", {63'd0, busy0}, 64'd0);
        chk("rst_prod", prod0, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("inrdy_after_rst", {63'd0, in_ready0}, 64'd1);

        // Unsigned 32-bit vectors
        issue32(32'd3, 32'd5, 1'b0, 64'd15);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        issue32(32'd0, 32'd0, 1'b0, 64'd0);
        issue32(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000);
        issue32(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h0000_0000_FFFF_FFFF);
        issue32(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001);
        drain();

        // Consumer stalls 10 cycles with a new request pending: held, no accept
        out_ready0 = 1'b0;
        issue32(32'd100, 32'd100, 1'b0, 64'h0000_0000_0000_2710);
        n = 0;
        while (!out_valid0 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) fail_now("done_timeout32");
        in_valid0 = 1'b1; a0 = 32'd1; b0 = 32'd1;
        repeat (10) begin @(posedge clk); #1; end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("xfer_ovalid", {63'd0, out_valid0}, 64'd0);
        chk("xfer_inrdy", {63'd0, in_ready0}, 64'd1);
        chk("xfer_busy", {63'd0, busy0}, 64'd0);

        // Reset in the middle of BUSY discards the operation
        issue32(32'd1234, 32'd5678, 1'b0, 64'd7006652);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", {63'd0, out_valid0}, 64'd0);
        chk("midrst_busy", {63'd0, busy0}, 64'd0);
        chk("midrst_prod", prod0, 64'd0);
        chk("midrst_inrdy", {63'd0, in_ready0}, 64'd0);
        eq0.delete(); et0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue32(32'd7, 32'd9, 1'b0, 64'd63);
        drain();

        // 8-bit instance boundaries
        issue8(8'h80, 8'h80, 1'b0, 16'h4000);
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        issue8(8'h03, 8'h05, 1'b0, 16'h000F);
        drain();

`ifdef MULT_SIGNED_EN
        issue32(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
        issue32(32'hFFFF_FFF9, 32'd6, 1'b0, 64'h0000_0005_FFFF_FFD6);
        issue32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue32(32'hFFFF_FFFF, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        drain();
        issue8(8'h80, 8'h80, 1'b1, 16'h4000);
        issue8(8'h80, 8'h7F, 1'b1, 16'hC080);
        issue8(8'h05, 8'hFD, 1'b1, 16'hFFF1);
        issue8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        drain();
`endif

        repeat (5) @(posedge clk);
        if (eq0.size() != 0 || eq1.size() != 0) fail_now("leftover_expected");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
